// File: rtl/serdes_word_align_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdes_word_align_ctrl_if : I_SERDES lane / fabric signals for word alignment
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serdes_word_align_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic             dpa_lock;
  logic             data_valid;
  logic [WIDTH-1:0] data_in;
  logic             bitslip_adj;
  logic             aligned;
  logic             align_error;
  logic [3:0]       slip_count;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;

  modport master (
    output enable, dpa_lock, data_valid, data_in,
    input  bitslip_adj, aligned, align_error, slip_count, data_out, data_out_valid
  );

  modport slave (
    input  enable, dpa_lock, data_valid, data_in,
    output bitslip_adj, aligned, align_error, slip_count, data_out, data_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/serdes_word_align_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdes_word_align_ctrl : DPA-lock wait, training-pattern check and bitslip
// Revision: 1.0
// ---------------------------------------------------------------------------
module serdes_word_align_ctrl #(
  parameter int               WIDTH         = 10,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 10'h3E0,
  parameter int               LOCK_WAIT     = 16,
  parameter int               MATCH_COUNT   = 8,
  parameter int               SLIP_GAP      = 4,
  parameter int               MAX_SLIPS     = 10
) (
  input  logic                     fabric_clk_div,
  input  logic                     reset_buf_n,
  serdes_word_align_ctrl_if.slave  lane_if
);

  localparam int LOCK_W  = $clog2(LOCK_WAIT + 1);
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int GAP_W   = $clog2(SLIP_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_CHECK     = 3'd2,
    S_SLIP      = 3'd3,
    S_SETTLE    = 3'd4,
    S_ALIGNED   = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t             state_q;
  logic [LOCK_W-1:0]  lock_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [3:0]         slip_cnt_q;
  logic               bitslip_q;
  logic               aligned_q;
  logic               error_q;
  logic [WIDTH-1:0]   data_out_q;
  logic               data_out_valid_q;

  logic lock_lost;
  assign lock_lost = !lane_if.dpa_lock &&
                     (state_q == S_CHECK || state_q == S_SLIP ||
                      state_q == S_SETTLE || state_q == S_ALIGNED);

  always_ff @(posedge fabric_clk_div or negedge reset_buf_n) begin
    if (!reset_buf_n) begin
      state_q          <= S_IDLE;
      lock_cnt_q       <= '0;
      match_cnt_q      <= '0;
      gap_cnt_q        <= '0;
      slip_cnt_q       <= '0;
      bitslip_q        <= 1'b0;
      aligned_q        <= 1'b0;
      error_q          <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else if (!lane_if.enable) begin
      // data_out deliberately holds its last word across a disable
      state_q          <= S_IDLE;
      lock_cnt_q       <= '0;
      match_cnt_q      <= '0;
      gap_cnt_q        <= '0;
      slip_cnt_q       <= '0;
      bitslip_q        <= 1'b0;
      aligned_q        <= 1'b0;
      error_q          <= 1'b0;
      data_out_valid_q <= 1'b0;
    end else if (lock_lost) begin
      state_q          <= S_WAIT_LOCK;
      lock_cnt_q       <= '0;
      match_cnt_q      <= '0;
      gap_cnt_q        <= '0;
      slip_cnt_q       <= '0;
      bitslip_q        <= 1'b0;
      aligned_q        <= 1'b0;
      data_out_valid_q <= 1'b0;
    end else begin
      bitslip_q        <= 1'b0;
      data_out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          lock_cnt_q  <= '0;
          match_cnt_q <= '0;
          gap_cnt_q   <= '0;
          slip_cnt_q  <= '0;
          state_q     <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (!lane_if.dpa_lock) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_W'(LOCK_WAIT - 1)) begin
            lock_cnt_q  <= '0;
            match_cnt_q <= '0;
            state_q     <= S_CHECK;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end
        S_CHECK: begin
          if (lane_if.data_valid) begin
            if (lane_if.data_in == TRAIN_PATTERN) begin
              if (match_cnt_q == MATCH_W'(MATCH_COUNT - 1)) begin
                match_cnt_q <= '0;
                aligned_q   <= 1'b1;
                state_q     <= S_ALIGNED;
              end else begin
                match_cnt_q <= match_cnt_q + MATCH_W'(1);
              end
            end else begin
              match_cnt_q <= '0;
              if (int'(slip_cnt_q) >= MAX_SLIPS) begin
                error_q <= 1'b1;
                state_q <= S_ERROR;
              end else begin
                bitslip_q <= 1'b1;
                state_q   <= S_SLIP;
              end
            end
          end
        end
        S_SLIP: begin
          if (slip_cnt_q != 4'hF) begin
            slip_cnt_q <= slip_cnt_q + 4'd1;
          end
          gap_cnt_q <= '0;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          // deserializer output is unreliable right after a slip, so
          // data_valid is not looked at here
          if (gap_cnt_q == GAP_W'(SLIP_GAP - 1)) begin
            gap_cnt_q   <= '0;
            match_cnt_q <= '0;
            state_q     <= S_CHECK;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        S_ALIGNED: begin
          aligned_q <= 1'b1;
          if (lane_if.data_valid) begin
            data_out_q       <= lane_if.data_in;
            data_out_valid_q <= 1'b1;
          end
        end
        S_ERROR: begin
          error_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lane_if.bitslip_adj    = bitslip_q;
  assign lane_if.aligned        = aligned_q;
  assign lane_if.align_error    = error_q;
  assign lane_if.slip_count     = slip_cnt_q;
  assign lane_if.data_out       = data_out_q;
  assign lane_if.data_out_valid = data_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_word_align_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serdes_word_align_ctrl : randomized lane model with scoreboard checking
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serdes_word_align_ctrl;

  localparam int         W           = 10;
  localparam logic [9:0] PAT         = 10'h3E0;
  localparam int         LOCK_WAIT   = 8;
  localparam int         MATCH_COUNT = 4;
  localparam int         SLIP_GAP    = 3;
  localparam int         MAX_SLIPS   = 10;

  logic fabric_clk_div = 1'b0;
  logic reset_buf_n    = 1'b0;

  serdes_word_align_ctrl_if #(.WIDTH(W)) aif ();

  serdes_word_align_ctrl #(
    .WIDTH(W), .TRAIN_PATTERN(PAT), .LOCK_WAIT(LOCK_WAIT),
    .MATCH_COUNT(MATCH_COUNT), .SLIP_GAP(SLIP_GAP), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .fabric_clk_div(fabric_clk_div),
    .reset_buf_n   (reset_buf_n),
    .lane_if       (aif.slave)
  );

  always #5 fabric_clk_div = ~fabric_clk_div;

  int          tests = 0;
  int          fails = 0;
  int          rot   = 0;
  int          gap   = 100;
  int          exp_slip_q[$];
  logic [W-1:0] exp_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops expected bitslip pulses and forwarded words
  always @(negedge fabric_clk_div) begin
    if (!reset_buf_n) begin
      gap = 100;
    end else begin
      if (aif.bitslip_adj) begin
        tests++;
        if (exp_slip_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_bitslip: pulse seen, none expected");
        end else begin
          void'(exp_slip_q.pop_front());
        end
        tests++;
        if (gap < SLIP_GAP + 1) begin
          fails++;
          $display("FAIL bitslip_spacing: %0d idle cycles, need >= %0d", gap, SLIP_GAP + 1);
        end
        gap = 0;
      end else if (gap < 100) begin
        gap++;
      end
      if (aif.data_out_valid) begin
        tests++;
        if (exp_words.size() == 0) begin
          fails++;
          $display("FAIL unexpected_data_out_valid: data_out=%0h, no word expected", aif.data_out);
        end else begin
          logic [W-1:0] w;
          w = exp_words.pop_front();
          if (aif.data_out !== w) begin
            fails++;
            $display("FAIL data_out: got %0h, expected %0h", aif.data_out, w);
          end
        end
      end
    end
  end

  // Lane model: each bitslip pulse removes one bit of word rotation
  task automatic step();
    @(posedge fabric_clk_div);
    #1;
    if (aif.bitslip_adj && rot > 0) rot--;
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int r);
    logic [W-1:0] t;
    t = w;
    for (int i = 0; i < r; i++) t = {t[W-2:0], t[W-1]};
    return t;
  endfunction

  task automatic idle(input int n);
    aif.data_valid = 1'b0;
    aif.data_in    = W'($urandom);
    repeat (n) step();
  endtask

  task automatic send(input logic [W-1:0] w);
    idle($urandom_range(0, 2));
    aif.data_valid = 1'b1;
    aif.data_in    = w;
    step();
    aif.data_valid = 1'b0;
  endtask

  task automatic settle_noise();
    repeat (SLIP_GAP + 1) begin
      aif.data_valid = 1'($urandom);
      aif.data_in    = W'($urandom);
      step();
    end
    aif.data_valid = 1'b0;
  endtask

  task automatic lock_up();
    aif.dpa_lock = 1'b1;
    idle(LOCK_WAIT + 2);
  endtask

  task automatic train(input int r);
    int guard;
    guard = 0;
    rot   = r;
    while (rot != 0 && guard < MAX_SLIPS + 4) begin
      exp_slip_q.push_back(guard);
      send(rotl(PAT, rot));
      settle_noise();
      guard++;
    end
    repeat (MATCH_COUNT - 1) send(PAT);
    check("aligned_early", 32'(aif.aligned), 32'd0);
    send(PAT);
    check("aligned", 32'(aif.aligned), 32'd1);
    check("slip_count_aligned", 32'(aif.slip_count), 32'(r));
    check("align_error_aligned", 32'(aif.align_error), 32'd0);
  endtask

  task automatic payload(input int n);
    logic [W-1:0] w;
    w = '0;
    repeat (n) begin
      w = W'($urandom);
      exp_words.push_back(w);
      send(w);
    end
    idle(2);
    check("data_out_hold", 32'(aif.data_out), 32'(w));
  endtask

  task automatic lock_timing(input bit glitch);
    aif.enable     = 1'b1;
    aif.dpa_lock   = 1'b0;
    aif.data_valid = 1'b1;
    aif.data_in    = PAT;
    step();
    if (glitch) begin
      aif.dpa_lock = 1'b1; step(); step(); step();
      aif.dpa_lock = 1'b0; step();
    end
    aif.dpa_lock = 1'b1;
    repeat (LOCK_WAIT + MATCH_COUNT - 1) step();
    check("lock_wait_aligned_early", 32'(aif.aligned), 32'd0);
    step();
    check("lock_wait_aligned", 32'(aif.aligned), 32'd1);
    check("lock_wait_slip_count", 32'(aif.slip_count), 32'd0);
    aif.data_valid = 1'b0;
  endtask

  task automatic status_zero(input string tag);
    check({tag, "_aligned"},     32'(aif.aligned),        32'd0);
    check({tag, "_align_error"}, 32'(aif.align_error),    32'd0);
    check({tag, "_slip_count"},  32'(aif.slip_count),     32'd0);
    check({tag, "_bitslip"},     32'(aif.bitslip_adj),    32'd0);
    check({tag, "_dout_valid"},  32'(aif.data_out_valid), 32'd0);
  endtask

  task automatic restart();
    aif.enable = 1'b0;
    step();
    aif.enable = 1'b1;
    lock_up();
  endtask

  task automatic reset_pulse();
    #2 reset_buf_n = 1'b0;
    #1;
    status_zero("async_reset");
    check("async_reset_data_out", 32'(aif.data_out), 32'd0);
    exp_slip_q.delete();
    exp_words.delete();
    @(posedge fabric_clk_div);
    #1 reset_buf_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w;
    aif.enable     = 1'b0;
    aif.dpa_lock   = 1'b0;
    aif.data_valid = 1'b0;
    aif.data_in    = '0;
    repeat (3) @(posedge fabric_clk_div);
    #1;
    status_zero("reset");
    check("reset_data_out", 32'(aif.data_out), 32'd0);
    reset_buf_n = 1'b1;
    step();

    // Clean lock, matching words every cycle, then lock with a glitch
    lock_timing(1'b0);
    payload(6);
    aif.enable = 1'b0;
    step();
    status_zero("disable");
    lock_timing(1'b1);
    payload(4);

    // Lane rotated by 3 bits
    restart();
    train(3);
    payload(6);

    // Lock loss while aligned, then relock and retrain
    aif.dpa_lock = 1'b0;
    step();
    check("lock_drop_aligned", 32'(aif.aligned), 32'd0);
    check("lock_drop_slip_count", 32'(aif.slip_count), 32'd0);
    step();
    lock_up();
    train($urandom_range(1, 9));
    payload(5);

    repeat (5) begin
      restart();
      train($urandom_range(0, 9));
      payload($urandom_range(3, 8));
    end

    // Training word never appears: slips run out
    restart();
    for (int i = 0; i <= MAX_SLIPS; i++) begin
      if (i < MAX_SLIPS) exp_slip_q.push_back(i);
      send(10'h155);
      if (i < MAX_SLIPS) settle_noise();
    end
    check("error_flag", 32'(aif.align_error), 32'd1);
    check("error_slip_count", 32'(aif.slip_count), 32'(MAX_SLIPS));
    check("error_aligned", 32'(aif.aligned), 32'd0);
    aif.dpa_lock = 1'b0;
    step(); step();
    check("error_ignores_lock", 32'(aif.align_error), 32'd1);
    aif.dpa_lock = 1'b1;
    aif.enable   = 1'b0;
    step();
    status_zero("error_exit");

    // Asynchronous reset while a bitslip pulse is on the wire
    aif.enable = 1'b1;
    lock_up();
    exp_slip_q.push_back(0);
    send(rotl(PAT, 5));
    check("slip_before_reset", 32'(aif.bitslip_adj), 32'd1);
    reset_pulse();

    // Asynchronous reset while aligned with a word being presented
    lock_up();
    train($urandom_range(0, 9));
    w = W'($urandom_range(1, 1023));
    exp_words.push_back(w);
    aif.data_valid = 1'b1;
    aif.data_in    = w;
    step();
    aif.data_valid = 1'b0;
    check("dout_valid_before_reset", 32'(aif.data_out_valid), 32'd1);
    reset_pulse();
    lock_up();
    train($urandom_range(0, 9));
    payload(4);

    idle(4);
    check("pending_words", 32'(exp_words.size()), 32'd0);
    check("pending_slips", 32'(exp_slip_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
